data_mem_access: RTL and testbench

Memory-stage access unit sitting directly downstream of the single-cycle datapath. It takes the ALU result as address, the store operand as write data, and the load/store request, then runs a valid/ready transaction on the external data bus. It stalls the core until the transaction completes and returns byte/halfword/word load data, sign- or zero-extended, on the datapath's read-data input. Misaligned or illegal requests and bus timeouts are reported on a fault line.

---
 rtl/data_mem_access.sv | 211 +++++++++++++++++++++
 tb/tb_data_mem_access.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_access.sv
// Memory-stage load/store unit: turns a datapath load/store into one valid/ready bus
// transaction, stalls the core until it completes and returns lane-formatted load data.
module data_mem_access #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_read,
    input  logic        i_req_write,
    input  logic [1:0]  i_size,
    input  logic        i_sign_ext,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_stall,
    output logic        o_fault,
    output logic        o_bus_valid,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_be,
    input  logic        i_bus_ready,
    input  logic [31:0] i_bus_rdata
);

    // state  | meaning
    // S_IDLE | waiting for a load/store; illegal requests fault here
    // S_REQ  | bus_valid asserted, waiting for bus_ready or timeout
    // S_DONE | one cycle where the core advances; request inputs ignored
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0] TC_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_cnt;
    logic        r_timeout;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_sign_ext;
    logic [1:0]  r_lsb;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;
    logic [3:0]  r_bus_be;
    logic [31:0] r_rdata;

    logic        w_req;
    logic        w_illegal;
    logic [3:0]  w_be;
    logic [31:0] w_wdata_rep;
    logic [7:0]  w_lane_byte;
    logic [15:0] w_lane_half;
    logic [31:0] w_load_fmt;
    logic        w_accept;
    logic        w_handshake;
    logic        w_expire;
    logic        w_stall;
    logic        w_fault;

    // Request decode and store lane steering
    always_comb begin
        w_req       = i_req_read | i_req_write;
        w_illegal   = (i_req_read & i_req_write)
                    | (i_size == 2'b11)
                    | ((i_size == 2'b01) & i_addr[0])
                    | ((i_size == 2'b10) & (i_addr[1:0] != 2'b00));
        w_be        = 4'b1111;
        w_wdata_rep = i_wdata;
        case (i_size)
            2'b00: begin
                w_be        = 4'b0001 << i_addr[1:0];
                w_wdata_rep = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                w_be        = i_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata_rep = {2{i_wdata[15:0]}};
            end
            default: begin
                w_be        = 4'b1111;
                w_wdata_rep = i_wdata;
            end
        endcase
    end

    // Load lane selection uses the offset latched at acceptance, not the live address
    always_comb begin
        w_lane_byte = i_bus_rdata[7:0];
        case (r_lsb)
            2'd0: w_lane_byte = i_bus_rdata[7:0];
            2'd1: w_lane_byte = i_bus_rdata[15:8];
            2'd2: w_lane_byte = i_bus_rdata[23:16];
            2'd3: w_lane_byte = i_bus_rdata[31:24];
            default: w_lane_byte = i_bus_rdata[7:0];
        endcase
        w_lane_half = r_lsb[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
        case (r_size)
            2'b00:   w_load_fmt = {{24{r_sign_ext & w_lane_byte[7]}}, w_lane_byte};
            2'b01:   w_load_fmt = {{16{r_sign_ext & w_lane_half[15]}}, w_lane_half};
            default: w_load_fmt = i_bus_rdata;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_fault     = 1'b0;
        w_accept    = 1'b0;
        w_handshake = 1'b0;
        w_expire    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (w_illegal) begin
                        w_fault = 1'b1;
                    end else begin
                        w_stall     = 1'b1;
                        w_accept    = 1'b1;
                        w_state_nxt = S_REQ;
                    end
                end
            end
            S_REQ: begin
                w_stall = 1'b1;
                if (i_bus_ready) begin
                    w_handshake = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (r_cnt == TC_LAST) begin
                    w_expire    = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_fault     = r_timeout;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt     <= 8'd0;
            r_timeout <= 1'b0;
        end else if (r_state == S_REQ) begin
            if (!i_bus_ready) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_expire) begin
                r_timeout <= 1'b1;
            end
        end else begin
            r_cnt     <= 8'd0;
            r_timeout <= 1'b0;
        end
    end

    // Bus request fields are captured once so they stay stable for the whole REQ phase
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_we        <= 1'b0;
            r_size      <= 2'b00;
            r_sign_ext  <= 1'b0;
            r_lsb       <= 2'b00;
            r_bus_addr  <= 32'd0;
            r_bus_wdata <= 32'd0;
            r_bus_be    <= 4'd0;
        end else if (w_accept) begin
            r_we        <= i_req_write;
            r_size      <= i_size;
            r_sign_ext  <= i_sign_ext;
            r_lsb       <= i_addr[1:0];
            r_bus_addr  <= {i_addr[31:2], 2'b00};
            r_bus_wdata <= w_wdata_rep;
            r_bus_be    <= w_be;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= 32'd0;
        end else if (!r_we) begin
            if (w_handshake) begin
                r_rdata <= w_load_fmt;
            end else if (w_expire) begin
                r_rdata <= 32'd0;
            end
        end
    end

    assign o_stall     = w_stall & i_rst_n;
    assign o_fault     = w_fault & i_rst_n;
    assign o_bus_valid = (r_state == S_REQ);
    assign o_bus_we    = r_we;
    assign o_bus_addr  = r_bus_addr;
    assign o_bus_wdata = r_bus_wdata;
    assign o_bus_be    = r_bus_be;
    assign o_rdata     = r_rdata;

endmodule

// File: tb/tb_data_mem_access.sv
// Self-checking bench for data_mem_access: a bus slave with programmable wait states
// and a scoreboard of expected load data popped at each access completion.
module tb_data_mem_access;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_req_read = 1'b0;
    logic        i_req_write = 1'b0;
    logic [1:0]  i_size = 2'b00;
    logic        i_sign_ext = 1'b0;
    logic [31:0] i_addr = 32'd0;
    logic [31:0] i_wdata = 32'd0;
    logic [31:0] o_rdata;
    logic        o_stall;
    logic        o_fault;
    logic        o_bus_valid;
    logic        o_bus_we;
    logic [31:0] o_bus_addr;
    logic [31:0] o_bus_wdata;
    logic [3:0]  o_bus_be;
    logic        i_bus_ready = 1'b0;
    logic [31:0] i_bus_rdata = 32'd0;

    int errors = 0;
    int checks = 0;
    logic [31:0] sb_q[$];
    logic [31:0] m_rdata = 32'd0;

    // access results
    int          a_stall, a_valid, a_fault, a_unstable;
    logic        a_we;
    logic [31:0] a_addr, a_wdata;
    logic [3:0]  a_be;

    data_mem_access #(.TIMEOUT_CYCLES(4)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_req_read(i_req_read), .i_req_write(i_req_write),
        .i_size(i_size), .i_sign_ext(i_sign_ext),
        .i_addr(i_addr), .i_wdata(i_wdata),
        .o_rdata(o_rdata), .o_stall(o_stall), .o_fault(o_fault),
        .o_bus_valid(o_bus_valid), .o_bus_we(o_bus_we),
        .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata), .o_bus_be(o_bus_be),
        .i_bus_ready(i_bus_ready), .i_bus_rdata(i_bus_rdata)
    );

    always #5 i_clk = ~i_clk;

    // Runs one request to completion; waits=0 means bus_ready tied high.
    task automatic run_access(input logic rd, input logic wr, input logic [1:0] sz,
                              input logic sx, input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] brd, input int waits);
        bit done = 0;
        logic [31:0] exp_rd;
        a_stall = 0; a_valid = 0; a_fault = 0; a_unstable = 0;
        a_we = 1'b0; a_addr = 32'd0; a_wdata = 32'd0; a_be = 4'd0;
        @(negedge i_clk);
        i_req_read = rd; i_req_write = wr; i_size = sz; i_sign_ext = sx;
        i_addr = a; i_wdata = wd; i_bus_rdata = brd;
        for (int c = 0; c < 200 && !done; c++) begin
            if (o_bus_valid) a_valid++;
            i_bus_ready = (waits == 0) || (o_bus_valid && (a_valid > waits));
            #1;
            if (o_stall) a_stall++;
            if (o_fault) a_fault++;
            if (o_bus_valid) begin
                if (a_valid == 1) begin
                    a_we = o_bus_we; a_addr = o_bus_addr; a_wdata = o_bus_wdata; a_be = o_bus_be;
                end else if ({o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be} !== {a_we, a_addr, a_wdata, a_be}) begin
                    a_unstable++;
                end
            end
            if (!o_stall && !o_bus_valid) begin
                done = 1;
                checks++;
                exp_rd = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hxxxxxxxx;
                if (o_rdata !== exp_rd) begin
                    errors++;
                    $display("FAIL sb_rdata: got %h expected %h (addr %h)", o_rdata, exp_rd, a);
                end
            end else begin
                @(negedge i_clk);
            end
        end
        i_req_read = 1'b0; i_req_write = 1'b0; i_bus_ready = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL access_timeout: got no completion expected completion within 200 cycles");
        end
        @(negedge i_clk);
        #1;
        checks++;
        if ({o_bus_valid, o_stall, o_fault} !== 3'b000) begin
            errors++;
            $display("FAIL idle_after: got valid/stall/fault=%b expected 000", {o_bus_valid, o_stall, o_fault});
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_req_read = 1'b1; i_size = 2'b10; i_addr = 32'h100;
        repeat (2) @(negedge i_clk);
        #1;
        checks++;
        if ({o_stall, o_fault, o_bus_valid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctl: got stall/fault/valid=%b expected 000", {o_stall, o_fault, o_bus_valid});
        end
        checks++;
        if ({o_rdata, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be} !== 101'd0) begin
            errors++;
            $display("FAIL reset_regs: got rdata=%h we=%b addr=%h wdata=%h be=%b expected all 0",
                     o_rdata, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be);
        end
        i_req_read = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic test_word_read();
        m_rdata = 32'hDEADBEEF;
        sb_q.push_back(m_rdata);
        run_access(1, 0, 2'b10, 0, 32'h10010004, 32'h0, 32'hDEADBEEF, 0);
        checks++;
        if ({a_addr, a_be, a_we} !== {32'h10010004, 4'b1111, 1'b0}) begin
            errors++;
            $display("FAIL word_bus: got addr=%h be=%b we=%b expected 10010004 1111 0", a_addr, a_be, a_we);
        end
        checks++;
        if (a_stall !== 2 || a_valid !== 1 || a_fault !== 0) begin
            errors++;
            $display("FAIL word_lat: got stall=%0d valid=%0d fault=%0d expected 2 1 0", a_stall, a_valid, a_fault);
        end
    endtask

    task automatic test_byte_read_waits();
        logic [31:0] exp_tab [2] = '{32'hFFFFFF80, 32'h00000080};
        for (int s = 0; s < 2; s++) begin
            m_rdata = exp_tab[s];
            sb_q.push_back(m_rdata);
            run_access(1, 0, 2'b00, (s == 0), 32'h10010003, 32'h0, 32'h80FF1234, 3);
            checks++;
            if (a_be !== 4'b1000 || a_addr !== 32'h10010000) begin
                errors++;
                $display("FAIL byte_bus: got be=%b addr=%h expected 1000 10010000", a_be, a_addr);
            end
            checks++;
            if (a_stall !== 5 || a_valid !== 4 || a_fault !== 0 || a_unstable !== 0) begin
                errors++;
                $display("FAIL byte_lat: got stall=%0d valid=%0d fault=%0d unstable=%0d expected 5 4 0 0",
                         a_stall, a_valid, a_fault, a_unstable);
            end
        end
    endtask

    task automatic test_half_write();
        sb_q.push_back(m_rdata);
        run_access(0, 1, 2'b01, 0, 32'h10010006, 32'h0000ABCD, 32'h12345678, 1);
        checks++;
        if ({a_we, a_be, a_wdata, a_addr} !== {1'b1, 4'b1100, 32'hABCDABCD, 32'h10010004}) begin
            errors++;
            $display("FAIL half_write: got we=%b be=%b wdata=%h addr=%h expected 1 1100 abcdabcd 10010004",
                     a_we, a_be, a_wdata, a_addr);
        end
        checks++;
        if (a_stall !== 3 || a_unstable !== 0) begin
            errors++;
            $display("FAIL half_write_lat: got stall=%0d unstable=%0d expected 3 0", a_stall, a_unstable);
        end
    endtask

    task automatic test_illegal();
        logic        rd_t [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic        wr_t [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [1:0]  sz_t [4] = '{2'b10, 2'b10, 2'b11, 2'b01};
        logic [31:0] ad_t [4] = '{32'h10010002, 32'h10010000, 32'h10010000, 32'h10010001};
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back(m_rdata);
            run_access(rd_t[i], wr_t[i], sz_t[i], 1, ad_t[i], 32'h55, 32'h0, 0);
            checks++;
            if (a_fault !== 1 || a_stall !== 0 || a_valid !== 0) begin
                errors++;
                $display("FAIL illegal_%0d: got fault=%0d stall=%0d valid=%0d expected 1 0 0",
                         i, a_fault, a_stall, a_valid);
            end
        end
    endtask

    task automatic test_lanes();
        logic [31:0] d, e, wd;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        for (int i = 0; i < 12; i++) begin
            int off = i % 4;
            bit half = (i >= 8);
            bit sx = i[0];
            if (half) off = (i % 2) * 2;
            d = $urandom() | 32'h80808080;
            if (!half) begin
                e = (d >> (8 * off)) & 32'hFF;
                if (sx && e[7]) e = e | 32'hFFFFFF00;
            end else begin
                e = (d >> (8 * off)) & 32'hFFFF;
                if (sx && e[15]) e = e | 32'hFFFF0000;
            end
            m_rdata = e;
            sb_q.push_back(m_rdata);
            run_access(1, 0, half ? 2'b01 : 2'b00, sx, 32'h20000000 + off, 32'h0, d, i % 3);
            checks++;
            if (a_stall !== 2 + (i % 3)) begin
                errors++;
                $display("FAIL lane_lat_%0d: got stall=%0d expected %0d", i, a_stall, 2 + (i % 3));
            end
        end
        for (int off = 0; off < 4; off++) begin
            wd = $urandom();
            ebe = 4'b0001 << off;
            ewd = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
            sb_q.push_back(m_rdata);
            run_access(0, 1, 2'b00, 0, 32'h30000000 + off, wd, 32'h0, 0);
            checks++;
            if (a_be !== ebe || a_wdata !== ewd || a_we !== 1'b1) begin
                errors++;
                $display("FAIL byte_write_%0d: got be=%b wdata=%h we=%b expected %b %h 1",
                         off, a_be, a_wdata, a_we, ebe, ewd);
            end
        end
        wd = 32'hCAFE1234;
        sb_q.push_back(m_rdata);
        run_access(0, 1, 2'b10, 0, 32'h30000008, wd, 32'h0, 0);
        checks++;
        if (a_be !== 4'b1111 || a_wdata !== wd) begin
            errors++;
            $display("FAIL word_write: got be=%b wdata=%h expected 1111 cafe1234", a_be, a_wdata);
        end
    endtask

    task automatic test_timeout();
        m_rdata = 32'd0;
        sb_q.push_back(m_rdata);
        run_access(1, 0, 2'b10, 0, 32'h10010008, 32'h0, 32'h11111111, 1000);
        checks++;
        if (a_valid !== 4 || a_fault !== 1 || a_stall !== 5 || a_unstable !== 0) begin
            errors++;
            $display("FAIL timeout: got valid=%0d fault=%0d stall=%0d unstable=%0d expected 4 1 5 0",
                     a_valid, a_fault, a_stall, a_unstable);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v [3] = '{32'h01020304, 32'hA5A5A5A5, 32'h7FFF0000};
        for (int i = 0; i < 3; i++) begin
            m_rdata = v[i];
            sb_q.push_back(m_rdata);
            run_access(1, 0, 2'b10, 1, 32'h40000000 + 4 * i, 32'h0, v[i], 0);
            checks++;
            if (a_stall !== 2 || a_addr !== 32'h40000000 + 4 * i) begin
                errors++;
                $display("FAIL b2b_%0d: got stall=%0d addr=%h expected 2 %h", i, a_stall, a_addr,
                         32'h40000000 + 4 * i);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge i_clk);
        i_req_read = 1'b1; i_size = 2'b10; i_addr = 32'h50000000; i_bus_ready = 1'b0;
        @(posedge i_clk);
        @(posedge i_clk);
        #3;
        checks++;
        if (o_bus_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_valid: got %b expected 1", o_bus_valid);
        end
        i_rst_n = 1'b0;
        #1;
        checks++;
        if ({o_bus_valid, o_stall, o_fault, o_rdata, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be} !== 104'd0) begin
            errors++;
            $display("FAIL mid_reset: got valid=%b stall=%b fault=%b rdata=%h addr=%h be=%b expected all 0",
                     o_bus_valid, o_stall, o_fault, o_rdata, o_bus_addr, o_bus_be);
        end
        i_req_read = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);
        #1;
        checks++;
        if (o_bus_valid !== 1'b0) begin
            errors++;
            $display("FAIL no_retry: got valid=%b expected 0", o_bus_valid);
        end
        m_rdata = 32'h600DF00D;
        sb_q.push_back(m_rdata);
        run_access(1, 0, 2'b10, 0, 32'h10010004, 32'h0, 32'h600DF00D, 0);
        checks++;
        if (a_stall !== 2 || a_addr !== 32'h10010004) begin
            errors++;
            $display("FAIL post_reset: got stall=%0d addr=%h expected 2 10010004", a_stall, a_addr);
        end
    endtask

    initial begin
        test_reset();
        test_word_read();
        test_byte_read_waits();
        test_half_write();
        test_illegal();
        test_lanes();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
